p4_req_driver: RTL and testbench
================================

// Module: p4_req_driver
// PURPOSE
//  Initiator side of the P4 adder interface: accepts operand requests on a valid/ready port,
//  drives registered A/B/cin into the P4 adder's input ports, and waits a fixed settle window.
//  It then samples S/cout and returns them on a valid/ready response port.
//  Sits between a sequential operand source (CPU datapath, test sequencer) and the combinational P4_ADDER.
// PARAMETERS
//  NBIT        16  operand/sum width; must match the connected adder
//  SETTLE_CYC  2   cycles from operand launch to result capture; legal range 1..15
// PORTS
//  clock      in   1     single clock; all state updates on rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  req_valid  in   1     request operands valid
//  req_ready  out  1     driver can accept a request
//  req_a      in   NBIT  operand A
//  req_b      in   NBIT  operand B
//  req_cin    in   1     carry-in
//  p4_a       out  NBIT  to adder A (registered)
//  p4_b       out  NBIT  to adder B (registered)
//  p4_cin     out  1     to adder cin (registered)
//  p4_s       in   NBIT  from adder S
//  p4_cout    in   1     from adder cout
//  rsp_valid  out  1     result valid
//  rsp_ready  in   1     consumer accepts result
//  rsp_s      out  NBIT  captured sum
//  rsp_cout   out  1     captured carry-out
//  busy       out  1     high in DRIVE or RESP
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, cnt=0, all outputs 0 except req_ready=1.
//  - FSM states IDLE, DRIVE, RESP.
//  - IDLE: req_ready=1. If req_valid=1 at edge k:
//    - latch req_a/b/cin into p4_a/b/cin;
//    - load cnt=SETTLE_CYC-1; go to DRIVE.
//  - DRIVE: req_ready=0. Each edge cnt decrements.
//    - At the edge where cnt==0 (edge k+SETTLE_CYC), capture p4_s->rsp_s and p4_cout->rsp_cout.
//    - Go to RESP; rsp_valid=1 from that edge.
//  - RESP: rsp_valid=1; rsp_s/rsp_cout stable until the handshake.
//    - rsp_valid & rsp_ready at an edge -> IDLE, rsp_valid=0.
//    - rsp_ready=0 holds RESP indefinitely (backpressure); no new request is accepted.
//  - Latency: accept at edge k -> rsp_valid visible after edge k+SETTLE_CYC.
//    - Minimum request-to-request spacing is SETTLE_CYC+2 cycles.
//    - No accept in the same cycle as the response handshake.
//  - p4_a/b/cin change only on an accepted request; they hold their last value in IDLE/RESP.
//    - The adder input is therefore glitch-free during capture.
//  - The sum is taken from the adder as-is. The driver does no arithmetic on the datapath.
//    - Width is NBIT for S; the carry is 1 bit; no truncation or extension.
//  - req_valid while not in IDLE is ignored (req_ready=0). The source must hold its operands.
//  - Reset mid-DRIVE/RESP: the in-flight op is dropped with no response; p4_* return to 0.
//  - SETTLE_CYC outside 1..15: elaboration-time $error.
// CONFIGURATION
//  P4_REFCHK_EN defined:
//    - Extra ports chk_err (out 1) and err_cnt (out 16).
//    - At capture, compare {p4_cout,p4_s} with p4_a+p4_b+p4_cin computed in NBIT+1 bits.
//    - On mismatch: chk_err=1 for the response beat; err_cnt increments, saturating at 16'hFFFF.
//    - Both reset to 0.
//  P4_REFCHK_EN undefined:
//    - No extra ports and no comparator logic; all other behaviour is identical.
// TESTING (NBIT=16, SETTLE_CYC=2, behavioural adder)
//  1. Reset released, req A=0x1234 B=0x0001 cin=0 at edge 0
//     -> rsp_valid after edge 2, rsp_s=0x1235, rsp_cout=0.
//  2. A=0xFFFF B=0x0001 cin=1 -> rsp_s=0x0001, rsp_cout=1 (wrap-around/carry).
//  3. rsp_ready=0 for 5 cycles after rsp_valid
//     -> rsp_valid/rsp_s held stable, req_ready=0, a second req_valid is ignored.
//  4. rst_n pulsed low during DRIVE -> no response, req_ready=1, p4_a=0 immediately (async).
//  5. Back-to-back requests with rsp_ready=1 -> accepts 4 cycles apart, responses in order.
//  6. P4_REFCHK_EN with an injected faulty adder (S forced to 0) on A=3 B=4
//     -> chk_err=1, err_cnt=1; a correct adder gives chk_err=0.

Source files
------------

// File: rtl/p4_req_driver.sv
// p4_req_driver: valid/ready initiator for a combinational P4 adder.
// Registers A/B/cin toward the adder, waits SETTLE_CYC edges, then returns S/cout on a response port.
// Ports: clock, rst_n (async, active low); req_valid/req_ready/req_a/req_b/req_cin;
//   p4_a/p4_b/p4_cin (to adder), p4_s/p4_cout (from adder);
//   rsp_valid/rsp_ready/rsp_s/rsp_cout; busy.
// Optional macro P4_REFCHK_EN adds chk_err and err_cnt, with a reference check at capture.
module p4_req_driver #(
  parameter int NBIT       = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [NBIT-1:0] req_a,
  input  logic [NBIT-1:0] req_b,
  input  logic            req_cin,
  output logic [NBIT-1:0] p4_a,
  output logic [NBIT-1:0] p4_b,
  output logic            p4_cin,
  input  logic [NBIT-1:0] p4_s,
  input  logic            p4_cout,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [NBIT-1:0] rsp_s,
  output logic            rsp_cout,
  output logic            busy
`ifdef P4_REFCHK_EN
  ,
  output logic            chk_err,
  output logic [15:0]     err_cnt
`endif
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("p4_req_driver: SETTLE_CYC must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    DRIVE = 3'b010,
    RESP  = 3'b100
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;
  logic       rsp_hs;

  assign accept  = (state == IDLE) && req_valid;
  assign capture = (state == DRIVE) && (cnt == 4'd0);
  assign rsp_hs  = (state == RESP) && rsp_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state[0]: if (req_valid) state_nx = DRIVE;
      state[1]: if (cnt == 4'd0) state_nx = RESP;
      state[2]: if (rsp_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      state[0]: req_ready = 1'b1;
      state[1]: busy = 1'b1;
      state[2]: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == DRIVE && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Adder inputs move only on accept, so they are quiet during capture.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      p4_a   <= '0;
      p4_b   <= '0;
      p4_cin <= 1'b0;
    end else if (accept) begin
      p4_a   <= req_a;
      p4_b   <= req_b;
      p4_cin <= req_cin;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
    end else if (capture) begin
      rsp_s    <= p4_s;
      rsp_cout <= p4_cout;
    end
  end

`ifdef P4_REFCHK_EN
  logic [NBIT:0] ref_sum;
  logic          mism;

  assign ref_sum = {1'b0, p4_a} + {1'b0, p4_b}
                 + {{NBIT{1'b0}}, p4_cin};
  assign mism    = {p4_cout, p4_s} != ref_sum;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
      err_cnt <= 16'd0;
    end else if (capture) begin
      chk_err <= mism;
      if (mism && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end else if (rsp_hs) begin
      chk_err <= 1'b0;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_p4_req_driver.sv
// Bench for p4_req_driver: behavioural adder, transaction-level model,
// per-cycle compare plus directed literal checks.
module tb_p4_req_driver;

  localparam int NBIT = 16;
  localparam int S    = 2;

  logic            clock = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [NBIT-1:0] req_a;
  logic [NBIT-1:0] req_b;
  logic            req_cin;
  logic [NBIT-1:0] p4_a;
  logic [NBIT-1:0] p4_b;
  logic            p4_cin;
  logic [NBIT-1:0] p4_s;
  logic            p4_cout;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [NBIT-1:0] rsp_s;
  logic            rsp_cout;
  logic            busy;
`ifdef P4_REFCHK_EN
  logic            chk_err;
  logic [15:0]     err_cnt;
  bit              fault = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  p4_req_driver #(.NBIT(NBIT), .SETTLE_CYC(S)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .p4_a      (p4_a),
    .p4_b      (p4_b),
    .p4_cin    (p4_cin),
    .p4_s      (p4_s),
    .p4_cout   (p4_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
`ifdef P4_REFCHK_EN
    ,
    .chk_err   (chk_err),
    .err_cnt   (err_cnt)
`endif
  );

  // Behavioural P4 adder
  logic [NBIT:0] add_out;
  assign add_out = {1'b0, p4_a} + {1'b0, p4_b} + {{NBIT{1'b0}}, p4_cin};
`ifdef P4_REFCHK_EN
  assign p4_s    = fault ? '0 : add_out[NBIT-1:0];
`else
  assign p4_s    = add_out[NBIT-1:0];
`endif
  assign p4_cout = add_out[NBIT];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: accept at edge k, response from edge k+S
  // until the handshake edge.
  bit            idle_m = 1'b1;
  bit            resp_m = 1'b0;
  logic [15:0]   ea = '0;
  logic [15:0]   eb = '0;
  logic          ec = 1'b0;
  logic [16:0]   ers = '0;
  logic [16:0]   pend = '0;
  int            cyc = 0;
  int            acc_edge = 0;
  int            acc_q[$];
`ifdef P4_REFCHK_EN
  bit            e_chk = 1'b0;
  int            e_cnt = 0;
`endif

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idle_m = 1'b1;
      resp_m = 1'b0;
      ea = '0;
      eb = '0;
      ec = 1'b0;
      ers = '0;
`ifdef P4_REFCHK_EN
      e_chk = 1'b0;
      e_cnt = 0;
`endif
    end else begin
      cyc++;
      if (idle_m && req_valid) begin
        idle_m = 1'b0;
        acc_edge = cyc;
        acc_q.push_back(cyc);
        ea = req_a;
        eb = req_b;
        ec = req_cin;
        pend = 17'(int'(req_a) + int'(req_b) + int'(req_cin));
      end else if (!idle_m && !resp_m && cyc == acc_edge + S) begin
        resp_m = 1'b1;
        ers = pend;
`ifdef P4_REFCHK_EN
        if (fault) ers[15:0] = '0;
        e_chk = (ers != pend);
        if (e_chk && e_cnt < 65535) e_cnt++;
`endif
      end else if (resp_m && rsp_ready) begin
        resp_m = 1'b0;
        idle_m = 1'b1;
`ifdef P4_REFCHK_EN
        e_chk = 1'b0;
`endif
      end
    end
  end

  always @(negedge clock) begin
    chk("req_ready", req_ready, idle_m);
    chk("busy", busy, !idle_m);
    chk("rsp_valid", rsp_valid, resp_m);
    chk("p4_a", p4_a, ea);
    chk("p4_b", p4_b, eb);
    chk("p4_cin", p4_cin, ec);
    chk("rsp_s", rsp_s, ers[15:0]);
    chk("rsp_cout", rsp_cout, ers[16]);
`ifdef P4_REFCHK_EN
    chk("chk_err", chk_err, e_chk);
    chk("err_cnt", err_cnt, e_cnt);
`endif
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready_to", 32'(n < 50), 32'd1);
    req_a = a;
    req_b = b;
    req_cin = c;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("rsp_timeout", 32'(n < 50), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_cin = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p4_a", p4_a, 0);
    rst_n = 1'b1;
    tick();

    // 1: latency
    req_a = 16'h1234;
    req_b = 16'h0001;
    req_cin = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t1_busy_e0", busy, 1);
    chk("t1_p4_a", p4_a, 16'h1234);
    tick();
    chk("t1_nrsp_e1", rsp_valid, 0);
    tick();
    chk("t1_rsp_e2", rsp_valid, 1);
    chk("t1_rsp_s", rsp_s, 16'h1235);
    chk("t1_rsp_cout", rsp_cout, 0);
    tick();
    chk("t1_done", rsp_valid, 0);

    // 2: carry wrap
    send(16'hFFFF, 16'h0001, 1'b1);
    wait_rsp();
    chk("t2_rsp_s", rsp_s, 16'h0001);
    chk("t2_rsp_cout", rsp_cout, 1);
    tick();

    // 3: backpressure, second request ignored
    rsp_ready = 1'b0;
    send(16'h0005, 16'h0006, 1'b0);
    wait_rsp();
    req_a = 16'hAAAA;
    req_b = 16'h5555;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_v", rsp_valid, 1);
      chk("t3_hold_s", rsp_s, 16'h000B);
      chk("t3_ready", req_ready, 0);
      chk("t3_p4_a", p4_a, 16'h0005);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("t3_release", rsp_valid, 0);

    // 4: async reset mid-DRIVE
    send(16'h0007, 16'h0008, 1'b0);
    chk("t4_in_drive", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_p4_a", p4_a, 0);
    chk("t4_ready", req_ready, 1);
    chk("t4_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_no_rsp", rsp_valid, 0);

    // 5: back-to-back, held valid
    acc_q.delete();
    begin
      logic [15:0] ta[3];
      logic [15:0] tb[3];
      logic        tc[3];
      ta = '{16'h0001, 16'h0100, 16'h8000};
      tb = '{16'h0002, 16'h0200, 16'h8000};
      tc = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
        int n;
        req_a = ta[i];
        req_b = tb[i];
        req_cin = tc[i];
        req_valid = 1'b1;
        n = 0;
        while (n < 20) begin
          @(negedge clock);
          if (req_ready) break;
          n++;
        end
        chk("t5_acc_to", 32'(n < 20), 32'd1);
        tick();
      end
      req_valid = 1'b0;
    end
    wait_rsp();
    chk("t5_last_s", rsp_s, 16'h0000);
    chk("t5_last_cout", rsp_cout, 1);
    tick();
    chk("t5_nacc", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("t5_gap0", acc_q[1] - acc_q[0], 4);
      chk("t5_gap1", acc_q[2] - acc_q[1], 4);
    end

`ifdef P4_REFCHK_EN
    // 6: reference check with a faulty adder
    fault = 1'b1;
    send(16'h0003, 16'h0004, 1'b0);
    wait_rsp();
    chk("t6_err", chk_err, 1);
    chk("t6_cnt", err_cnt, 1);
    tick();
    fault = 1'b0;
    send(16'h0003, 16'h0004, 1'b0);
    wait_rsp();
    chk("t6_ok", chk_err, 0);
    chk("t6_cnt2", err_cnt, 1);
    chk("t6_s", rsp_s, 16'h0007);
    tick();
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
